// File: rtl/text_grid_scanner_pkg.sv
// Shared types and constants for the text grid scanner: keyboard opcodes,
// controller states and the glyph index used for an empty cell.
package text_grid_scanner_pkg;

    typedef enum logic [1:0] {
        OP_CHAR  = 2'd0,
        OP_BKSP  = 2'd1,
        OP_NL    = 2'd2,
        OP_CLEAR = 2'd3
    } key_op_t;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [15:0] BLANK_CHAR = 16'd0;

    // True when a grid placed at origin with the given pixel extent stays within the counter range.
    function automatic bit fits_raster(input int origin, input int extent, input int max_val);
        return (origin + extent) <= max_val;
    endfunction

endpackage

// File: rtl/text_grid_scanner_if.sv
// Keyboard command handshake into the text grid: one command moves when key_valid && key_ready.
interface text_grid_scanner_if;
    import text_grid_scanner_pkg::*;

    logic        key_valid;
    key_op_t     key_op;
    logic [15:0] key_code;
    logic        key_ready;

    modport master (output key_valid, key_op, key_code, input key_ready);
    modport slave  (input key_valid, key_op, key_code, output key_ready);

endinterface

// File: rtl/text_grid_scanner_char_ram.sv
// Character cell storage: one write port, one registered read port, read-first on collision.
module text_char_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9,
    parameter int DW    = 16
) (
    input  logic          pixel_clk_in,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge pixel_clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_grid_scanner.sv
// Text grid owner: keyboard-driven cursor/edit FSM plus a raster-locked scan that feeds
// alphabet_sprite the glyph index and tile origin of every pixel, two cycles after hcount_in.
//
//  state    | meaning
//  ST_CLEAR | sweeping BLANK_CHAR into every cell, one per cycle; commands refused
//  ST_IDLE  | accepting one keyboard command per cycle
module text_grid_scanner
    import text_grid_scanner_pkg::*;
#(
    parameter int COLS     = 32,
    parameter int ROWS     = 16,
    parameter int CHAR_W   = 20,
    parameter int CHAR_H   = 18,
    parameter int ORIGIN_X = 64,
    parameter int ORIGIN_Y = 96
) (
    input  logic                     pixel_clk_in,
    input  logic                     rst_n_in,
    input  logic [10:0]              hcount_in,
    input  logic [9:0]               vcount_in,
    text_grid_scanner_if.slave       key,
    output logic [15:0]              char_out,
    output logic [10:0]              tile_x_out,
    output logic [9:0]               tile_y_out,
    output logic [10:0]              hcount_out,
    output logic [9:0]               vcount_out,
    output logic                     in_grid_out,
    output logic [$clog2(COLS)-1:0]  cursor_col_out,
    output logic [$clog2(ROWS)-1:0]  cursor_row_out
);

    localparam int CW  = $clog2(COLS);
    localparam int RW  = $clog2(ROWS);
    localparam int AW  = CW + RW;
    localparam int SXW = $clog2(CHAR_W);
    localparam int SYW = $clog2(CHAR_H);

    localparam logic [CW-1:0]  C_ONE     = CW'(1);
    localparam logic [RW-1:0]  R_ONE     = RW'(1);
    localparam logic [AW-1:0]  A_ONE     = AW'(1);
    localparam logic [SXW-1:0] SX_ONE    = SXW'(1);
    localparam logic [SYW-1:0] SY_ONE    = SYW'(1);
    localparam logic [CW-1:0]  COL_LAST  = CW'(COLS - 1);
    localparam logic [AW-1:0]  CELL_LAST = AW'(COLS * ROWS - 1);
    localparam logic [SXW-1:0] SX_LAST   = SXW'(CHAR_W - 1);
    localparam logic [SYW-1:0] SY_LAST   = SYW'(CHAR_H - 1);
    localparam logic [10:0]    X_LO      = 11'(ORIGIN_X);
    localparam logic [10:0]    X_HI      = 11'(ORIGIN_X + COLS * CHAR_W);
    localparam logic [9:0]     Y_LO      = 10'(ORIGIN_Y);
    localparam logic [9:0]     Y_HI      = 10'(ORIGIN_Y + ROWS * CHAR_H);
    localparam logic [10:0]    STEP_X    = 11'(CHAR_W);
    localparam logic [9:0]     STEP_Y    = 10'(CHAR_H);

    // Elaboration-time guard: tile origins are plain 11/10-bit sums and must never wrap.
    if (!fits_raster(ORIGIN_X, COLS * CHAR_W, 2047) || !fits_raster(ORIGIN_Y, ROWS * CHAR_H, 1023)
        || (1 << CW) != COLS || (1 << RW) != ROWS) begin : g_geometry_check
        $error("text_grid_scanner: grid geometry does not fit the raster counters");
    end

    state_t        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [15:0]   wdata;

    assign key.key_ready  = (state_q == ST_IDLE);
    assign cursor_col_out = cur_col_q;
    assign cursor_row_out = cur_row_q;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            cur_col_q <= '0;
            cur_row_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cur_col_q <= cur_col_d;
            cur_row_q <= cur_row_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        cur_col_d = cur_col_q;
        cur_row_d = cur_row_q;
        we        = 1'b0;
        waddr     = {cur_row_q, cur_col_q};
        wdata     = BLANK_CHAR;
        case (state_q)
            ST_CLEAR: begin
                we        = 1'b1;
                waddr     = clr_idx_q;
                clr_idx_d = clr_idx_q + A_ONE;
                if (clr_idx_q == CELL_LAST) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = '0;
                    cur_col_d = '0;
                    cur_row_d = '0;
                end
            end
            ST_IDLE: begin
                if (key.key_valid) begin
                    case (key.key_op)
                        OP_CHAR: begin
                            we        = 1'b1;
                            wdata     = key.key_code;
                            cur_col_d = cur_col_q + C_ONE;
                            if (cur_col_q == COL_LAST) begin
                                cur_row_d = cur_row_q + R_ONE;
                            end
                        end
                        // Backspace steps back one cell (wrapping to the previous row) and blanks it.
                        OP_BKSP: begin
                            if (cur_col_q != '0) begin
                                cur_col_d = cur_col_q - C_ONE;
                                we        = 1'b1;
                            end else if (cur_row_q != '0) begin
                                cur_col_d = COL_LAST;
                                cur_row_d = cur_row_q - R_ONE;
                                we        = 1'b1;
                            end
                            waddr = {cur_row_d, cur_col_d};
                        end
                        OP_NL: begin
                            cur_col_d = '0;
                            cur_row_d = cur_row_q + R_ONE;
                        end
                        OP_CLEAR: begin
                            state_d   = ST_CLEAR;
                            clr_idx_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

    logic [SXW-1:0] sub_x_q, sub_x_d;
    logic [CW-1:0]  col_q, col_d;
    logic [10:0]    tile_x_q, tile_x_d;
    logic [SYW-1:0] sub_y_q, sub_y_d;
    logic [RW-1:0]  row_q, row_d;
    logic [9:0]     tile_y_q, tile_y_d;
    logic           in_grid_d, in_grid_q;
    logic [10:0]    hcount_q;
    logic [9:0]     vcount_q;
    logic [15:0]    rd_data;

    // Counter-only scan; the _d values describe the pixel on hcount_in this cycle.
    always_comb begin
        sub_x_d  = sub_x_q + SX_ONE;
        col_d    = col_q;
        tile_x_d = tile_x_q;
        if (hcount_in == X_LO) begin
            sub_x_d  = '0;
            col_d    = '0;
            tile_x_d = X_LO;
        end else if (sub_x_q == SX_LAST) begin
            sub_x_d  = '0;
            col_d    = col_q + C_ONE;
            tile_x_d = tile_x_q + STEP_X;
        end

        sub_y_d  = sub_y_q;
        row_d    = row_q;
        tile_y_d = tile_y_q;
        if (hcount_in == '0) begin
            if (vcount_in == Y_LO) begin
                sub_y_d  = '0;
                row_d    = '0;
                tile_y_d = Y_LO;
            end else if (sub_y_q == SY_LAST) begin
                sub_y_d  = '0;
                row_d    = row_q + R_ONE;
                tile_y_d = tile_y_q + STEP_Y;
            end else begin
                sub_y_d = sub_y_q + SY_ONE;
            end
        end
    end

    assign in_grid_d = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                       (vcount_in >= Y_LO) && (vcount_in < Y_HI);

    text_char_ram #(.DEPTH(COLS * ROWS), .AW(AW), .DW(16)) u_char_ram (
        .pixel_clk_in (pixel_clk_in),
        .we           (we),
        .waddr        (waddr),
        .wdata        (wdata),
        .raddr        ({row_d, col_d}),
        .rdata        (rd_data)
    );

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sub_x_q     <= '0;
            col_q       <= '0;
            tile_x_q    <= '0;
            sub_y_q     <= '0;
            row_q       <= '0;
            tile_y_q    <= '0;
            in_grid_q   <= 1'b0;
            hcount_q    <= '0;
            vcount_q    <= '0;
            char_out    <= BLANK_CHAR;
            tile_x_out  <= '0;
            tile_y_out  <= '0;
            in_grid_out <= 1'b0;
            hcount_out  <= '0;
            vcount_out  <= '0;
        end else begin
            sub_x_q     <= sub_x_d;
            col_q       <= col_d;
            tile_x_q    <= tile_x_d;
            sub_y_q     <= sub_y_d;
            row_q       <= row_d;
            tile_y_q    <= tile_y_d;
            in_grid_q   <= in_grid_d;
            hcount_q    <= hcount_in;
            vcount_q    <= vcount_in;
            char_out    <= in_grid_q ? rd_data : BLANK_CHAR;
            in_grid_out <= in_grid_q;
            hcount_out  <= hcount_q;
            vcount_out  <= vcount_q;
            if (in_grid_q) begin
                tile_x_out <= tile_x_q;
                tile_y_out <= tile_y_q;
            end
        end
    end

endmodule

// File: tb/tb_text_grid_scanner.sv
// Self-checking bench: random keyboard traffic and sampled raster frames against a cell-array model.
module tb_text_grid_scanner;
    import text_grid_scanner_pkg::*;

    localparam int COLS    = 32;
    localparam int ROWS    = 16;
    localparam int CHAR_W  = 20;
    localparam int CHAR_H  = 18;
    localparam int OX      = 64;
    localparam int OY      = 96;
    localparam int CELLS   = COLS * ROWS;
    localparam int H_TOTAL = 710;
    localparam int V_TOTAL = 400;

    logic        pixel_clk_in = 1'b0;
    logic        rst_n_in     = 1'b0;
    logic [10:0] hcount_in    = '0;
    logic [9:0]  vcount_in    = '0;
    logic [15:0] char_out;
    logic [10:0] tile_x_out;
    logic [9:0]  tile_y_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        in_grid_out;
    logic [4:0]  cursor_col_out;
    logic [3:0]  cursor_row_out;

    text_grid_scanner_if key_if ();

    text_grid_scanner dut (
        .pixel_clk_in   (pixel_clk_in),
        .rst_n_in       (rst_n_in),
        .hcount_in      (hcount_in),
        .vcount_in      (vcount_in),
        .key            (key_if),
        .char_out       (char_out),
        .tile_x_out     (tile_x_out),
        .tile_y_out     (tile_y_out),
        .hcount_out     (hcount_out),
        .vcount_out     (vcount_out),
        .in_grid_out    (in_grid_out),
        .cursor_col_out (cursor_col_out),
        .cursor_row_out (cursor_row_out)
    );

    always #5 pixel_clk_in = ~pixel_clk_in;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int          grid [CELLS];
    int          cur_pos, clear_left;
    int          q0_h, q0_v, q1_h, q1_v;
    int          exp_tx, exp_ty;
    int          ig_count;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic bit line_sel(input int v);
        int last;
        last = OY + ROWS * CHAR_H;
        if (v == OY - 1 || v == OY || v == last - 1 || v == last) return 1'b1;
        if (v > OY && v < last)
            return ((v - OY) % CHAR_H) == (((v - OY) / CHAR_H) * 5) % CHAR_H;
        return 1'b0;
    endfunction

    task automatic model_reset();
        q0_h = 0; q0_v = 0; q1_h = 0; q1_v = 0;
        exp_tx = 0; exp_ty = 0;
        cur_pos = 0;
        clear_left = CELLS;
        foreach (grid[i]) grid[i] = 0;
    endtask

    task automatic model_apply(input int op, input int code);
        case (op)
            0: begin grid[cur_pos] = code; cur_pos = (cur_pos + 1) % CELLS; end
            1: if (cur_pos > 0) begin cur_pos--; grid[cur_pos] = 0; end
            2: cur_pos = ((cur_pos / COLS + 1) % ROWS) * COLS;
            default: begin clear_left = CELLS + 1; foreach (grid[i]) grid[i] = 0; end
        endcase
    endtask

    task automatic check_outputs();
        bit ig;
        int col, row, exp_char;
        ig = (q1_h >= OX) && (q1_h < OX + COLS * CHAR_W) && (q1_v >= OY) && (q1_v < OY + ROWS * CHAR_H);
        exp_char = 0;
        if (ig) begin
            col = (q1_h - OX) / CHAR_W;
            row = (q1_v - OY) / CHAR_H;
            exp_char = grid[row * COLS + col];
            exp_tx = OX + col * CHAR_W;
            exp_ty = OY + row * CHAR_H;
        end
        check_val("in_grid", longint'(in_grid_out), longint'(ig));
        check_val("char", longint'(char_out), longint'(exp_char));
        check_val("tile_x", longint'(tile_x_out), longint'(exp_tx));
        check_val("tile_y", longint'(tile_y_out), longint'(exp_ty));
        check_val("hcount_dly", longint'(hcount_out), longint'(q1_h));
        check_val("vcount_dly", longint'(vcount_out), longint'(q1_v));
        check_val("key_ready", longint'(key_if.key_ready), longint'(clear_left == 0));
        check_val("cursor_col", longint'(cursor_col_out), longint'(cur_pos % COLS));
        check_val("cursor_row", longint'(cursor_row_out), longint'(cur_pos / COLS));
        if (in_grid_out) ig_count++;
    endtask

    task automatic tick(input int h, input int v);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        @(posedge pixel_clk_in);
        q1_h = q0_h; q1_v = q0_v;
        q0_h = h;    q0_v = v;
        if (clear_left > 0) begin
            clear_left--;
            if (clear_left == 0) cur_pos = 0;
        end
        @(negedge pixel_clk_in);
        check_outputs();
    endtask

    task automatic send_cmd(input int op, input int code);
        key_if.key_valid = 1'b1;
        key_if.key_op    = key_op_t'(op);
        key_if.key_code  = 16'(code);
        if (clear_left == 0) model_apply(op, code);
        tick(0, 0);
        key_if.key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        while (clear_left > 0) tick(0, 0);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        key_if.key_valid = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        repeat (3) @(negedge pixel_clk_in);
        check_val("rst_char", longint'(char_out), 0);
        check_val("rst_ready", longint'(key_if.key_ready), 0);
        check_val("rst_cursor", longint'({cursor_row_out, cursor_col_out}), 0);
        check_val("rst_tile_x", longint'(tile_x_out), 0);
        check_val("rst_in_grid", longint'(in_grid_out), 0);
        check_val("rst_hcount", longint'(hcount_out), 0);
        model_reset();
        rst_n_in = 1'b1;
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        while (key_if.key_ready !== 1'b1 && n < 2000) begin
            n++;
            tick(0, 0);
        end
        check_val(tag, longint'(n), 512);
    endtask

    task automatic scan_frame(input string tag);
        int exp_cnt;
        ig_count = 0;
        exp_cnt  = 0;
        for (int v = 0; v < V_TOTAL; v++) begin
            if (line_sel(v)) begin
                for (int h = 0; h < H_TOTAL; h++) tick(h, v);
                if (v >= OY && v < OY + ROWS * CHAR_H) exp_cnt += COLS * CHAR_W;
            end else begin
                tick(0, v);
            end
        end
        tick(0, 0);
        tick(0, 0);
        check_val({tag, "_grid_px"}, longint'(ig_count), longint'(exp_cnt));
    endtask

    initial begin
        int r;
        key_if.key_valid = 1'b0;
        key_if.key_op    = OP_CHAR;
        key_if.key_code  = '0;

        // Power-up clear sweep, then an all-blank frame.
        do_reset();
        count_clear("clear_len");
        scan_frame("blank");

        // Typing, wrap at the last cell, backspace at home, row-wrapping backspace, newline wrap.
        send_cmd(0, 5);
        send_cmd(0, 7);
        send_cmd(0, 9);
        repeat (15) send_cmd(2, 0);
        repeat (31) send_cmd(0, int'($urandom_range(1, 65535)));
        send_cmd(0, 3);
        send_cmd(1, 0);
        send_cmd(2, 0);
        repeat (32) send_cmd(0, int'($urandom_range(1, 65535)));
        send_cmd(1, 0);
        repeat (14) send_cmd(2, 0);
        send_cmd(2, 0);
        tick(0, 0);
        scan_frame("edits");

        // Random command traffic, including occasional clears with commands refused meanwhile.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      send_cmd(0, int'($urandom_range(0, 65535)));
            else if (r < 70) send_cmd(1, 0);
            else if (r < 85) send_cmd(2, 0);
            else if (r < 87) send_cmd(3, 0);
            else             tick(0, 0);
        end
        wait_idle();
        scan_frame("random");

        // Clear interrupted by reset: refused command, then a complete fresh sweep.
        repeat (10) send_cmd(0, int'($urandom_range(1, 65535)));
        send_cmd(3, 0);
        repeat (40) tick(0, 0);
        send_cmd(0, 16'h55);
        repeat (59) tick(0, 0);
        do_reset();
        count_clear("clear_len_rst");
        scan_frame("after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
